// File: rtl/merge_wrr_arbiter_if.sv
// Handshake bundle for the two-producer merge: L0/L1 valid/ready inputs and the
// registered output channel with its source tag.
interface merge_wrr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             l0_valid;
    logic [WIDTH-1:0] l0_data;
    logic             l0_ready;
    logic             l1_valid;
    logic [WIDTH-1:0] l1_data;
    logic             l1_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_ready;

    modport slave (
        input  l0_valid, l0_data, l1_valid, l1_data, r_ready,
        output l0_ready, l1_ready, r_valid, r_data, r_sel
    );

    modport master (
        output l0_valid, l0_data, l1_valid, l1_data, r_ready,
        input  l0_ready, l1_ready, r_valid, r_data, r_sel
    );
endinterface

// File: rtl/merge_wrr_arbiter.sv
// Two-input merge with weighted round-robin grant into a single output register.
// Define MERGE_WRR_STATS_EN to add saturating per-side transfer counters.
module merge_wrr_arbiter #(
    parameter int WIDTH = 4,
    parameter int W0    = 1,
    parameter int W1    = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    merge_wrr_arbiter_if.slave bus
`ifdef MERGE_WRR_STATS_EN
    ,
    output logic [15:0]       gnt0_cnt,
    output logic [15:0]       gnt1_cnt
`endif
);
    typedef enum logic {SEL_L0 = 1'b0, SEL_L1 = 1'b1} sel_e;

    localparam logic [CNT_W-1:0] W0_LAST = CNT_W'(W0 - 1);
    localparam logic [CNT_W-1:0] W1_LAST = CNT_W'(W1 - 1);

    sel_e             cur_q, cur_d, g, g_n;
    logic [CNT_W-1:0] cnt_q, cnt_d, w_last, c_eff;
    logic             r_valid_q, r_valid_d;
    logic             r_sel_q, r_sel_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             can_load, any_vld, xfer;

    always_comb begin
        can_load = !r_valid_q || bus.r_ready;
        any_vld  = bus.l0_valid || bus.l1_valid;
        if (bus.l0_valid && bus.l1_valid) g = cur_q;
        else if (bus.l1_valid)            g = SEL_L1;
        else                              g = SEL_L0;
        g_n    = (g == SEL_L0) ? SEL_L1 : SEL_L0;
        xfer   = rst_n && can_load && any_vld;
        w_last = (g == SEL_L1) ? W1_LAST : W0_LAST;
        // A grant to the non-current side starts a fresh burst, so it counts from 0.
        c_eff  = (g == cur_q) ? cnt_q : '0;
    end

    assign bus.l0_ready = xfer && (g == SEL_L0);
    assign bus.l1_ready = xfer && (g == SEL_L1);
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_sel    = r_sel_q;

    always_comb begin
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_sel_d   = r_sel_q;
        if (xfer) begin
            r_valid_d = 1'b1;
            r_data_d  = (g == SEL_L1) ? bus.l1_data : bus.l0_data;
            r_sel_d   = (g == SEL_L1);
            if (c_eff == w_last) begin
                cur_d = g_n;
                cnt_d = '0;
            end else begin
                cur_d = g;
                cnt_d = c_eff + CNT_W'(1);
            end
        end else if (r_valid_q && bus.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q     <= SEL_L0;
            cnt_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_sel_q   <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_sel_q   <= r_sel_d;
        end
    end

`ifdef MERGE_WRR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (bus.l0_ready && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
            if (bus.l1_ready && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_merge_wrr_arbiter.sv
// Directed bench for merge_wrr_arbiter: three instances with different weights
// share one stimulus set; `dut` selects whose outputs are checked.
module tb_merge_wrr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       l0v, l1v, rr;
    logic [3:0] l0d, l1d;
    int         dut = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    merge_wrr_arbiter_if #(.WIDTH(4)) if_a ();
    merge_wrr_arbiter_if #(.WIDTH(4)) if_b ();
    merge_wrr_arbiter_if #(.WIDTH(4)) if_c ();

    assign if_a.l0_valid = l0v; assign if_a.l0_data = l0d; assign if_a.l1_valid = l1v;
    assign if_a.l1_data  = l1d; assign if_a.r_ready = rr;
    assign if_b.l0_valid = l0v; assign if_b.l0_data = l0d; assign if_b.l1_valid = l1v;
    assign if_b.l1_data  = l1d; assign if_b.r_ready = rr;
    assign if_c.l0_valid = l0v; assign if_c.l0_data = l0d; assign if_c.l1_valid = l1v;
    assign if_c.l1_data  = l1d; assign if_c.r_ready = rr;

`ifdef MERGE_WRR_STATS_EN
    logic [15:0] g0_a, g1_a, g0_b, g1_b, g0_c, g1_c;
`endif

    merge_wrr_arbiter #(.WIDTH(4), .W0(3), .W1(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
`ifdef MERGE_WRR_STATS_EN
        , .gnt0_cnt(g0_a), .gnt1_cnt(g1_a)
`endif
    );
    merge_wrr_arbiter #(.WIDTH(4), .W0(2), .W1(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
`ifdef MERGE_WRR_STATS_EN
        , .gnt0_cnt(g0_b), .gnt1_cnt(g1_b)
`endif
    );
    merge_wrr_arbiter #(.WIDTH(4), .W0(4), .W1(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
`ifdef MERGE_WRR_STATS_EN
        , .gnt0_cnt(g0_c), .gnt1_cnt(g1_c)
`endif
    );

    logic       o_l0r, o_l1r, o_rv, o_rsel;
    logic [3:0] o_rd;
    always_comb begin
        case (dut)
            1:       begin o_l0r = if_b.l0_ready; o_l1r = if_b.l1_ready; o_rv = if_b.r_valid;
                           o_rsel = if_b.r_sel; o_rd = if_b.r_data; end
            2:       begin o_l0r = if_c.l0_ready; o_l1r = if_c.l1_ready; o_rv = if_c.r_valid;
                           o_rsel = if_c.r_sel; o_rd = if_c.r_data; end
            default: begin o_l0r = if_a.l0_ready; o_l1r = if_a.l1_ready; o_rv = if_a.r_valid;
                           o_rsel = if_a.r_sel; o_rd = if_a.r_data; end
        endcase
    end

    // Stimulus legality: a pending valid must hold with stable data until accepted.
    logic       pend0 = 1'b0, pend1 = 1'b0;
    logic [3:0] pd0 = '0, pd1 = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pend0) assert (l0v && l0d == pd0) else $error("L0 valid/data changed before transfer");
            if (pend1) assert (l1v && l1d == pd1) else $error("L1 valid/data changed before transfer");
        end
        pend0 <= (rst_n === 1'b1) && l0v && !o_l0r;
        pend1 <= (rst_n === 1'b1) && l1v && !o_l1r;
        pd0   <= l0d;
        pd1   <= l1d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; l0v = 1'b0; l1v = 1'b0; rr = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // Expect a transfer from side s this cycle and packet d in the register after it.
    task automatic xfer_chk(input string tag, input logic s, input logic [3:0] d);
        #1;
        chk({tag, ".l0_ready"}, {31'b0, o_l0r}, {31'b0, !s});
        chk({tag, ".l1_ready"}, {31'b0, o_l1r}, {31'b0, s});
        cyc();
        chk({tag, ".r_valid"}, {31'b0, o_rv}, 32'd1);
        chk({tag, ".r_sel"}, {31'b0, o_rsel}, {31'b0, s});
        chk({tag, ".r_data"}, {28'b0, o_rd}, {28'b0, d});
    endtask

    logic [3:0] n0, n1;
    logic       s;

    initial begin
        // Reset held with both inputs requesting.
        dut = 0;
        rst_n = 1'b0; l0v = 1'b1; l1v = 1'b1; l0d = 4'd1; l1d = 4'd15; rr = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst.r_valid", {31'b0, o_rv}, 32'd0);
        chk("rst.r_data", {28'b0, o_rd}, 32'd0);
        chk("rst.r_sel", {31'b0, o_rsel}, 32'd0);
        chk("rst.l0_ready", {31'b0, o_l0r}, 32'd0);
        chk("rst.l1_ready", {31'b0, o_l1r}, 32'd0);
        rst_n = 1'b1;

        // W0=3, W1=1: 0,0,0,1 repeating, first grant to L0.
        n0 = 4'd1; n1 = 4'd15;
        for (int k = 0; k < 16; k++) begin
            s = (k % 4 == 3);
            xfer_chk("wrr", s, s ? n1 : n0);
            if (s) begin n1 = n1 - 4'd1; l1d = n1; end
            else   begin n0 = n0 + 4'd1; l0d = n0; end
        end
`ifdef MERGE_WRR_STATS_EN
        chk("wrr.gnt0_cnt", {16'b0, g0_a}, 32'd12);
        chk("wrr.gnt1_cnt", {16'b0, g1_a}, 32'd4);
`endif

        // Backpressure: register holds last L1 packet (12), no grants, weight kept.
        rr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp.l0_ready", {31'b0, o_l0r}, 32'd0);
            chk("bp.l1_ready", {31'b0, o_l1r}, 32'd0);
            cyc();
            chk("bp.r_valid", {31'b0, o_rv}, 32'd1);
            chk("bp.r_data", {28'b0, o_rd}, 32'd12);
            chk("bp.r_sel", {31'b0, o_rsel}, 32'd1);
        end
        rr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = (k == 3);
            xfer_chk("bp_resume", s, s ? n1 : n0);
            if (s) begin n1 = n1 - 4'd1; l1d = n1; end
            else   begin n0 = n0 + 4'd1; l0d = n0; end
        end
`ifdef MERGE_WRR_STATS_EN
        chk("bp.gnt0_cnt", {16'b0, g0_a}, 32'd15);
        chk("bp.gnt1_cnt", {16'b0, g1_a}, 32'd5);
`endif

        // Single source: only L1, data 1..5, back-to-back.
        do_reset();
        #1;
        chk("single.r_valid0", {31'b0, o_rv}, 32'd0);
        l1v = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            l1d = 4'(d);
            xfer_chk("single", 1'b1, 4'(d));
        end
        l1v = 1'b0;
        cyc();
        chk("single.drain", {31'b0, o_rv}, 32'd0);

        // Idle switch, W0=W1=2: L0 alone, then both -> one more L0, then 2x L1.
        dut = 1;
        do_reset();
        l0v = 1'b1; l0d = 4'd3;
        xfer_chk("idle", 1'b0, 4'd3);
        l0d = 4'd4; l1v = 1'b1; l1d = 4'd9;
        xfer_chk("idle", 1'b0, 4'd4);
        l0d = 4'd5;
        xfer_chk("idle", 1'b1, 4'd9);
        l1d = 4'd10;
        xfer_chk("idle", 1'b1, 4'd10);
        xfer_chk("idle", 1'b0, 4'd5);

        // L1 alone first: it takes over cur with one grant already spent.
        do_reset();
        l1v = 1'b1; l1d = 4'd2;
        xfer_chk("idle1", 1'b1, 4'd2);
        l0v = 1'b1; l0d = 4'd6; l1d = 4'd3;
        xfer_chk("idle1", 1'b1, 4'd3);
        l1d = 4'd4;
        xfer_chk("idle1", 1'b0, 4'd6);
        l0d = 4'd7;
        xfer_chk("idle1", 1'b0, 4'd7);
        l0d = 4'd8;
        xfer_chk("idle1", 1'b1, 4'd4);

        // Reset mid-burst, W0=4: two L0 grants, reset drops the packet, full burst after.
        dut = 2;
        do_reset();
        l0v = 1'b1; l1v = 1'b1; l0d = 4'd1; l1d = 4'd9;
        xfer_chk("mid", 1'b0, 4'd1);
        l0d = 4'd2;
        xfer_chk("mid", 1'b0, 4'd2);
        l0d = 4'd3; rst_n = 1'b0;
        #1;
        chk("mid.rst_l0_ready", {31'b0, o_l0r}, 32'd0);
        chk("mid.rst_l1_ready", {31'b0, o_l1r}, 32'd0);
        cyc();
        chk("mid.rst_r_valid", {31'b0, o_rv}, 32'd0);
        chk("mid.rst_r_data", {28'b0, o_rd}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            xfer_chk("mid_burst", 1'b0, 4'(3 + k));
            l0d = 4'(4 + k);
        end
        xfer_chk("mid_burst", 1'b1, 4'd9);
`ifdef MERGE_WRR_STATS_EN
        chk("mid.gnt0_cnt", {16'b0, g0_c}, 32'd4);
        chk("mid.gnt1_cnt", {16'b0, g1_c}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/merge_wrr_arbiter.md
Name: merge_wrr_arbiter

Overview:
- Clocked two-input merge controller with a weighted round-robin (WRR) arbiter.
- Shares one output channel between two requesters (L0, L1), each using a valid/ready handshake.
- Registers the winning packet together with a source tag (r_sel); downstream logic uses r_sel to demultiplex or to drive a merge select channel.
- Sits in front of a PE input port so that two upstream producers feed one consumer.

Parameters:
- WIDTH, 4, packet width in bits.
- W0, 1, burst weight of L0: consecutive grants to L0 while both request (range 1..255).
- W1, 1, burst weight of L1 (range 1..255).
- CNT_W, 8, width of the burst counter; must satisfy 2^CNT_W > max(W0,W1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- l0_valid  in  1  L0 has a packet.
- l0_data  in  WIDTH  L0 packet.
- l0_ready  out  1  L0 packet accepted this cycle (combinational).
- l1_valid  in  1  L1 has a packet.
- l1_data  in  WIDTH  L1 packet.
- l1_ready  out  1  L1 packet accepted this cycle (combinational).
- r_valid  out  1  output register holds a packet.
- r_data  out  WIDTH  output packet.
- r_sel  out  1  source of r_data: 0 = L0, 1 = L1.
- r_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets r_valid=0, r_data=0, r_sel=0, cur=0, cnt=0. A mid-operation reset drops any held packet. While rst_n=0, l0_ready and l1_ready are 0.
- Handshake: a transfer occurs on a channel when valid && ready at a rising edge. Once valid is asserted it must hold with stable data until the transfer completes.
- Output stage is a single entry.
  - can_load = !r_valid || r_ready.
  - When can_load is true and a grant exists, the granted packet loads at the edge.
  - Else, if r_valid && r_ready, r_valid clears.
- Latency: 1 cycle from the input handshake to r_valid. Throughput is 1 packet per cycle under continuous r_ready.
- Grant g (combinational):
  - Both valid: g = cur.
  - Only L0 valid: g = 0.
  - Only L1 valid: g = 1.
  - Neither valid: no grant.
- Ready outputs:
  - l0_ready = can_load && grant exists && g==0.
  - l1_ready = can_load && grant exists && g==1.
  - Never both 1 in the same cycle.
- State update on each input transfer from g, with Wg the weight of g:
  - g==cur and cnt==Wg-1: cur <= ~cur, cnt <= 0.
  - g==cur otherwise: cnt <= cnt+1.
  - g!=cur (the other side was idle): cur <= g and cnt <= 1. If Wg==1, instead cur <= ~g and cnt <= 0.
  - No transfer: cur and cnt hold. A stalled output does not consume weight.
- Fairness: with both inputs continuously valid and r_ready=1, the grant pattern repeats as W0 grants to L0 then W1 grants to L1.
- Simultaneous events:
  - Output drain and reload in the same cycle is allowed; r_valid stays 1 and new data appears.
  - Input valid deasserting without a transfer is illegal stimulus; the bench asserts on it.
- r_data and r_sel change only on a load.

Optional Feature:
- Macro: MERGE_WRR_STATS_EN.
- Defined: adds output ports gnt0_cnt[15:0] and gnt1_cnt[15:0].
  - Each counts the input transfers from its side.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with l0_valid=l1_valid=1 -> r_valid=0, l0_ready=l1_ready=0, r_data=0. After release, the first grant goes to L0 (cur=0).
- Single source: only L1 valid, sending data 1..5, r_ready=1 -> r_data=1,2,3,4,5 with r_sel=1 on consecutive cycles, 1-cycle latency, l0_ready always 0.
- WRR ratio: W0=3, W1=1, both always valid, r_ready=1, 16 transfers -> r_sel sequence 0,0,0,1 repeating. With MERGE_WRR_STATS_EN: gnt0_cnt=12, gnt1_cnt=4.
- Backpressure: r_ready=0 for 5 cycles while both valid -> r_valid=1 and r_data held. Both l*_ready stay 0 after the first load, and cur/cnt stay unchanged. Releasing r_ready resumes the exact WRR sequence.
- Idle switch: W0=W1=2. L0 sends 1 packet, L1 idle, then both valid -> L0 gets one more grant (cnt=1 -> 2), then L1 gets 2 grants.
- Reset mid-burst: W0=4, reset asserted after 2 L0 grants while r_valid=1 -> held packet dropped, r_valid=0. After release, L0 receives a full 4-grant burst.
